// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared ALU op encodings and ID/EX control word layout
package id_ex_stage_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_XOR = 3'd5,
        ALU_NOR = 3'd6,
        ALU_SLL = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] alu_op;
    } ctl_t;

    localparam ctl_t        BUBBLE_CTL = '0;
    localparam logic [15:0] BUBBLE_MAX = 16'hFFFF;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-stage inputs and ID/EX register outputs of the pipeline stage
interface id_ex_stage_if;
    logic        flush_i;
    logic        ctl_reg_write_i, ctl_mem_read_i, ctl_mem_write_i;
    logic        ctl_mem_to_reg_i, ctl_alu_src_i, ctl_reg_dst_i;
    logic [2:0]  ctl_alu_op_i;
    logic [31:0] read_data_1_i, read_data_2_i, imm_ext_i, pc_plus_4_i;
    logic [4:0]  reg_rs_i, reg_rt_i, reg_rd_i;
    logic        ctl_reg_write_IDEX_o, ctl_mem_read_IDEX_o, ctl_mem_write_IDEX_o;
    logic        ctl_mem_to_reg_IDEX_o, ctl_alu_src_IDEX_o, ctl_reg_dst_IDEX_o;
    logic [2:0]  ctl_alu_op_IDEX_o;
    logic [31:0] read_data_1_IDEX_o, read_data_2_IDEX_o, imm_ext_IDEX_o, pc_plus_4_IDEX_o;
    logic [4:0]  reg_rs_IDEX_o, reg_rt_IDEX_o, reg_rd_IDEX_o;
    logic        pc_write_o, if_id_write_o, stall_o;
    logic [15:0] bubble_count_o;

    modport master (
        output flush_i, ctl_reg_write_i, ctl_mem_read_i, ctl_mem_write_i,
               ctl_mem_to_reg_i, ctl_alu_src_i, ctl_reg_dst_i, ctl_alu_op_i,
               read_data_1_i, read_data_2_i, imm_ext_i, pc_plus_4_i,
               reg_rs_i, reg_rt_i, reg_rd_i,
        input  ctl_reg_write_IDEX_o, ctl_mem_read_IDEX_o, ctl_mem_write_IDEX_o,
               ctl_mem_to_reg_IDEX_o, ctl_alu_src_IDEX_o, ctl_reg_dst_IDEX_o,
               ctl_alu_op_IDEX_o, read_data_1_IDEX_o, read_data_2_IDEX_o,
               imm_ext_IDEX_o, pc_plus_4_IDEX_o, reg_rs_IDEX_o, reg_rt_IDEX_o,
               reg_rd_IDEX_o, pc_write_o, if_id_write_o, stall_o, bubble_count_o
    );

    modport slave (
        input  flush_i, ctl_reg_write_i, ctl_mem_read_i, ctl_mem_write_i,
               ctl_mem_to_reg_i, ctl_alu_src_i, ctl_reg_dst_i, ctl_alu_op_i,
               read_data_1_i, read_data_2_i, imm_ext_i, pc_plus_4_i,
               reg_rs_i, reg_rt_i, reg_rd_i,
        output ctl_reg_write_IDEX_o, ctl_mem_read_IDEX_o, ctl_mem_write_IDEX_o,
               ctl_mem_to_reg_IDEX_o, ctl_alu_src_IDEX_o, ctl_reg_dst_IDEX_o,
               ctl_alu_op_IDEX_o, read_data_1_IDEX_o, read_data_2_IDEX_o,
               imm_ext_IDEX_o, pc_plus_4_IDEX_o, reg_rs_IDEX_o, reg_rt_IDEX_o,
               reg_rd_IDEX_o, pc_write_o, if_id_write_o, stall_o, bubble_count_o
    );
endinterface

// File: rtl/id_ex_stage_hazard_detection_unit.sv
// hazard_detection_unit: combinational load-use detector; a flushed ID instruction never stalls
module hazard_detection_unit (
    input  logic       i_idex_mem_read,
    input  logic [4:0] i_idex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_flush,
    output logic       o_stall
);
    assign o_stall = i_idex_mem_read && (i_idex_rt != 5'd0) &&
                     ((i_idex_rt == i_id_rs) || (i_idex_rt == i_id_rt)) && !i_flush;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubbles and a saturating bubble counter
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);
    ctl_t        r_ctl;
    logic [31:0] r_rd1, r_rd2, r_imm, r_pc4;
    logic [4:0]  r_rs, r_rt, r_rd;
    logic [15:0] r_bubble_count;
    ctl_t        w_ctl_in;
    logic        w_stall, w_bubble;

    assign w_ctl_in = {bus.ctl_reg_write_i, bus.ctl_mem_read_i, bus.ctl_mem_write_i,
                       bus.ctl_mem_to_reg_i, bus.ctl_alu_src_i, bus.ctl_reg_dst_i,
                       bus.ctl_alu_op_i};

    hazard_detection_unit u_hdu (
        .i_idex_mem_read (r_ctl.mem_read),
        .i_idex_rt       (r_rt),
        .i_id_rs         (bus.reg_rs_i),
        .i_id_rt         (bus.reg_rt_i),
        .i_flush         (bus.flush_i),
        .o_stall         (w_stall)
    );

    // A stall and a flush in the same cycle still insert only one bubble
    assign w_bubble = w_stall | bus.flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctl          <= BUBBLE_CTL;
            r_rd1          <= '0;
            r_rd2          <= '0;
            r_imm          <= '0;
            r_pc4          <= '0;
            r_rs           <= '0;
            r_rt           <= '0;
            r_rd           <= '0;
            r_bubble_count <= '0;
        end else begin
            r_ctl <= w_bubble ? BUBBLE_CTL : w_ctl_in;
            r_rd1 <= bus.read_data_1_i;
            r_rd2 <= bus.read_data_2_i;
            r_imm <= bus.imm_ext_i;
            r_pc4 <= bus.pc_plus_4_i;
            r_rs  <= bus.reg_rs_i;
            r_rt  <= bus.reg_rt_i;
            r_rd  <= bus.reg_rd_i;
            if (w_bubble && r_bubble_count != BUBBLE_MAX)
                r_bubble_count <= r_bubble_count + 16'd1;
        end
    end

    assign bus.ctl_reg_write_IDEX_o  = r_ctl.reg_write;
    assign bus.ctl_mem_read_IDEX_o   = r_ctl.mem_read;
    assign bus.ctl_mem_write_IDEX_o  = r_ctl.mem_write;
    assign bus.ctl_mem_to_reg_IDEX_o = r_ctl.mem_to_reg;
    assign bus.ctl_alu_src_IDEX_o    = r_ctl.alu_src;
    assign bus.ctl_reg_dst_IDEX_o    = r_ctl.reg_dst;
    assign bus.ctl_alu_op_IDEX_o     = r_ctl.alu_op;
    assign bus.read_data_1_IDEX_o    = r_rd1;
    assign bus.read_data_2_IDEX_o    = r_rd2;
    assign bus.imm_ext_IDEX_o        = r_imm;
    assign bus.pc_plus_4_IDEX_o      = r_pc4;
    assign bus.reg_rs_IDEX_o         = r_rs;
    assign bus.reg_rt_IDEX_o         = r_rt;
    assign bus.reg_rd_IDEX_o         = r_rd;
    assign bus.stall_o               = w_stall;
    assign bus.pc_write_o            = ~w_stall;
    assign bus.if_id_write_o         = ~w_stall;
    assign bus.bubble_count_o        = r_bubble_count;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for the ID/EX stage; a reference model predicts each registered state
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset;
    id_ex_stage_if bus();

    id_ex_stage dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // ctl bit order: reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[2:0]
    typedef struct packed {
        logic [8:0]  ctl;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rs, rt, rd;
        logic [15:0] cnt;
    } idex_t;

    idex_t m;
    idex_t q[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [8:0] in_ctl();
        return {bus.ctl_reg_write_i, bus.ctl_mem_read_i, bus.ctl_mem_write_i, bus.ctl_mem_to_reg_i,
                bus.ctl_alu_src_i, bus.ctl_reg_dst_i, bus.ctl_alu_op_i};
    endfunction

    function automatic idex_t observed();
        idex_t o;
        o.ctl = {bus.ctl_reg_write_IDEX_o, bus.ctl_mem_read_IDEX_o, bus.ctl_mem_write_IDEX_o,
                 bus.ctl_mem_to_reg_IDEX_o, bus.ctl_alu_src_IDEX_o, bus.ctl_reg_dst_IDEX_o,
                 bus.ctl_alu_op_IDEX_o};
        o.rd1 = bus.read_data_1_IDEX_o;
        o.rd2 = bus.read_data_2_IDEX_o;
        o.imm = bus.imm_ext_IDEX_o;
        o.pc4 = bus.pc_plus_4_IDEX_o;
        o.rs  = bus.reg_rs_IDEX_o;
        o.rt  = bus.reg_rt_IDEX_o;
        o.rd  = bus.reg_rd_IDEX_o;
        o.cnt = bus.bubble_count_o;
        return o;
    endfunction

    function automatic logic exp_stall();
        return m.ctl[7] && (m.rt != 5'd0) && ((m.rt == bus.reg_rs_i) || (m.rt == bus.reg_rt_i)) && !bus.flush_i;
    endfunction

    function automatic idex_t predict();
        idex_t n;
        logic bub;
        bub   = exp_stall() || bus.flush_i;
        n.ctl = bub ? 9'd0 : in_ctl();
        n.rd1 = bus.read_data_1_i;
        n.rd2 = bus.read_data_2_i;
        n.imm = bus.imm_ext_i;
        n.pc4 = bus.pc_plus_4_i;
        n.rs  = bus.reg_rs_i;
        n.rt  = bus.reg_rt_i;
        n.rd  = bus.reg_rd_i;
        n.cnt = (bub && m.cnt != 16'hFFFF) ? m.cnt + 16'd1 : m.cnt;
        return n;
    endfunction

    task automatic set_in(input logic [8:0] c, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] im, input logic [31:0] pc,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic fl);
        {bus.ctl_reg_write_i, bus.ctl_mem_read_i, bus.ctl_mem_write_i, bus.ctl_mem_to_reg_i,
         bus.ctl_alu_src_i, bus.ctl_reg_dst_i, bus.ctl_alu_op_i} = c;
        bus.read_data_1_i = d1;
        bus.read_data_2_i = d2;
        bus.imm_ext_i     = im;
        bus.pc_plus_4_i   = pc;
        bus.reg_rs_i      = rs;
        bus.reg_rt_i      = rt;
        bus.reg_rd_i      = rd;
        bus.flush_i       = fl;
    endtask

    task automatic tick();
        idex_t n;
        n = predict();
        q.push_back(n);
        @(posedge clk);
        #1;
        m = n;
    endtask

    task automatic test_reset();
        idex_t got;
        reset = 1'b1;
        set_in(9'h1FF, 32'hDEAD_BEEF, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 5'd7, 5'd7, 5'd7, 1'b0);
        #2;
        got = observed();
        checks++;
        if (got !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", got); end
        checks++;
        if ({bus.stall_o, bus.pc_write_o, bus.if_id_write_o} !== 3'b011)
            begin failures++; $display("FAIL reset_stall got=%b exp=011", {bus.stall_o, bus.pc_write_o, bus.if_id_write_o}); end
        @(posedge clk);
        #1;
        got = observed();
        checks++;
        if (got !== '0) begin failures++; $display("FAIL reset_held got=%h exp=0", got); end
        reset = 1'b0;
        m = '0;
        q.delete();
    endtask

    task automatic test_pass_through();
        idex_t got, exp;
        set_in(9'b1_0_0_0_0_1_010, 32'h1234_5678, 32'hCAFE_0001, 32'h0000_0010, 32'h0000_0104, 5'd3, 5'd4, 5'd5, 1'b0);
        #1;
        checks++;
        if ({bus.stall_o, bus.pc_write_o, bus.if_id_write_o} !== 3'b011)
            begin failures++; $display("FAIL pass_stall got=%b exp=011", {bus.stall_o, bus.pc_write_o, bus.if_id_write_o}); end
        tick();
        exp = q.pop_front();
        got = observed();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL pass_state got=%h exp=%h", got, exp); end
        checks++;
        if (bus.read_data_1_IDEX_o !== 32'h1234_5678 || bus.reg_rd_IDEX_o !== 5'd5 || bus.ctl_reg_write_IDEX_o !== 1'b1)
            begin failures++; $display("FAIL pass_fields got=%h/%0d/%b exp=12345678/5/1", bus.read_data_1_IDEX_o, bus.reg_rd_IDEX_o, bus.ctl_reg_write_IDEX_o); end
    endtask

    task automatic test_load_use();
        idex_t got, exp;
        logic [15:0] c0;
        set_in(9'b1_1_0_1_1_0_000, 32'h0000_1000, 32'h0, 32'h0000_0020, 32'h0000_0108, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        exp = q.pop_front();
        got = observed();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL lu_load got=%h exp=%h", got, exp); end
        set_in(9'b1_0_0_0_0_1_001, 32'hAAAA_0000, 32'h5555_0000, 32'h0, 32'h0000_010C, 5'd8, 5'd2, 5'd9, 1'b0);
        #1;
        checks++;
        if ({bus.stall_o, bus.pc_write_o, bus.if_id_write_o} !== 3'b100)
            begin failures++; $display("FAIL lu_stall got=%b exp=100", {bus.stall_o, bus.pc_write_o, bus.if_id_write_o}); end
        c0 = m.cnt;
        tick();
        exp = q.pop_front();
        got = observed();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL lu_bubble got=%h exp=%h", got, exp); end
        checks++;
        if (got.ctl !== 9'd0 || bus.bubble_count_o !== c0 + 16'd1)
            begin failures++; $display("FAIL lu_count got=%h/%0d exp=0/%0d", got.ctl, bus.bubble_count_o, c0 + 16'd1); end
        checks++;
        if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", bus.stall_o); end
        tick();
        exp = q.pop_front();
        got = observed();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL lu_retry got=%h exp=%h", got, exp); end
    endtask

    task automatic test_load_zero();
        idex_t got, exp;
        logic [15:0] c0;
        set_in(9'b1_1_0_1_1_0_000, 32'h4, 32'h0, 32'h8, 32'h110, 5'd2, 5'd0, 5'd0, 1'b0);
        tick();
        exp = q.pop_front();
        got = observed();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL lz_load got=%h exp=%h", got, exp); end
        set_in(9'b1_0_0_0_0_1_011, 32'h7, 32'h9, 32'h0, 32'h114, 5'd0, 5'd0, 5'd6, 1'b0);
        #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL lz_stall got=%b exp=0", bus.stall_o); end
        c0 = m.cnt;
        tick();
        exp = q.pop_front();
        got = observed();
        checks++;
        if (got !== exp || bus.bubble_count_o !== c0)
            begin failures++; $display("FAIL lz_state got=%h exp=%h cnt=%0d/%0d", got, exp, bus.bubble_count_o, c0); end
    endtask

    task automatic test_flush_over_stall();
        idex_t got, exp;
        logic [15:0] c0;
        set_in(9'b1_1_0_1_1_0_000, 32'h10, 32'h0, 32'h4, 32'h118, 5'd3, 5'd8, 5'd0, 1'b0);
        tick();
        exp = q.pop_front();
        got = observed();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL fl_load got=%h exp=%h", got, exp); end
        set_in(9'b1_0_1_0_1_1_101, 32'h21, 32'h22, 32'h23, 32'h11C, 5'd8, 5'd8, 5'd4, 1'b1);
        #1;
        checks++;
        if ({bus.stall_o, bus.pc_write_o, bus.if_id_write_o} !== 3'b011)
            begin failures++; $display("FAIL fl_stall got=%b exp=011", {bus.stall_o, bus.pc_write_o, bus.if_id_write_o}); end
        c0 = m.cnt;
        tick();
        exp = q.pop_front();
        got = observed();
        checks++;
        if (got !== exp || got.ctl !== 9'd0 || bus.bubble_count_o !== c0 + 16'd1)
            begin failures++; $display("FAIL fl_bubble got=%h exp=%h cnt=%0d/%0d", got, exp, bus.bubble_count_o, c0 + 16'd1); end
    endtask

    task automatic test_back_to_back();
        idex_t got, exp;
        for (int i = 0; i < 300; i++) begin
            set_in(9'($urandom), $urandom, $urandom, $urandom, $urandom,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 7) == 0));
            #1;
            checks++;
            if ({bus.stall_o, bus.pc_write_o, bus.if_id_write_o} !== {exp_stall(), !exp_stall(), !exp_stall()})
                begin failures++; $display("FAIL b2b_stall i=%0d got=%b exp=%b", i, bus.stall_o, exp_stall()); end
            tick();
            exp = q.pop_front();
            got = observed();
            checks++;
            if (got !== exp) begin failures++; $display("FAIL b2b_state i=%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_saturation();
        idex_t got, exp;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m = '0;
        q.delete();
        set_in(9'h1FF, 32'h1, 32'h2, 32'h3, 32'h4, 5'd1, 5'd2, 5'd3, 1'b1);
        for (int i = 0; i < 65534; i++) tick();
        q.delete();
        checks++;
        if (bus.bubble_count_o !== 16'd65534) begin failures++; $display("FAIL sat_preload got=%0d exp=65534", bus.bubble_count_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = q.pop_front();
            got = observed();
            checks++;
            if (got !== exp || bus.bubble_count_o !== 16'hFFFF)
                begin failures++; $display("FAIL sat_hold i=%0d got=%h exp=%h cnt=%h", i, got, exp, bus.bubble_count_o); end
        end
    endtask

    task automatic test_async_reset();
        idex_t got, exp;
        set_in(9'b1_1_0_1_1_0_000, 32'h40, 32'h0, 32'h8, 32'h200, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        void'(q.pop_front());
        set_in(9'b1_0_0_0_0_1_010, 32'h77, 32'h88, 32'h99, 32'h204, 5'd8, 5'd3, 5'd12, 1'b0);
        #1;
        checks++;
        if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL ar_prestall got=%b exp=1", bus.stall_o); end
        #2;
        reset = 1'b1;
        #1;
        got = observed();
        checks++;
        if (got !== '0) begin failures++; $display("FAIL ar_clear got=%h exp=0", got); end
        checks++;
        if ({bus.stall_o, bus.pc_write_o, bus.if_id_write_o} !== 3'b011)
            begin failures++; $display("FAIL ar_stall got=%b exp=011", {bus.stall_o, bus.pc_write_o, bus.if_id_write_o}); end
        m = '0;
        q.delete();
        #1;
        reset = 1'b0;
        tick();
        exp = q.pop_front();
        got = observed();
        checks++;
        if (got !== exp || bus.ctl_reg_write_IDEX_o !== 1'b1)
            begin failures++; $display("FAIL ar_resume got=%h exp=%h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use();
        test_load_zero();
        test_flush_over_stall();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port flush_i  input  1  discard the ID-stage instruction (taken branch/jump).
REQ-004 SHALL have ports ctl_reg_write_i, ctl_mem_read_i, ctl_mem_write_i, ctl_mem_to_reg_i, ctl_alu_src_i, ctl_reg_dst_i  input  1 each  ID-stage control bits.
REQ-005 SHALL have port ctl_alu_op_i  input  3  ID-stage ALU operation code.
REQ-006 SHALL have ports read_data_1_i, read_data_2_i, imm_ext_i, pc_plus_4_i  input  32 each  ID-stage operands.
REQ-007 SHALL have ports reg_rs_i, reg_rt_i, reg_rd_i  input  5 each  register fields of the ID-stage instruction.
REQ-008 SHALL have registered outputs named as inputs with suffix _IDEX_o (e.g. reg_rs_IDEX_o, ctl_reg_write_IDEX_o), same widths.
REQ-009 SHALL have port pc_write_o  output  1  PC load enable (0 = hold PC).
REQ-010 SHALL have port if_id_write_o  output  1  IF/ID register load enable (0 = hold).
REQ-011 SHALL have port stall_o  output  1  load-use stall active this cycle.
REQ-012 SHALL have port bubble_count_o  output  16  saturating count of inserted bubbles.

Function
REQ-013 SHALL assert stall_o combinationally when ctl_mem_read_IDEX_o=1, reg_rt_IDEX_o!=0, and reg_rt_IDEX_o equals reg_rs_i or reg_rt_i, and flush_i=0.
REQ-014 SHALL drive pc_write_o = if_id_write_o = ~stall_o.
REQ-015 flush_i=1 SHALL suppress stall_o (discarded instruction cannot stall); pc_write_o=1.
REQ-016 Normal cycle (no stall, no flush): all _IDEX_o outputs SHALL take the corresponding inputs on the next rising edge (latency 1).
REQ-017 Bubble cycle (stall_o=1 or flush_i=1): all ctl_* IDEX outputs, including ctl_alu_op, SHALL load 0; data and register-field outputs SHALL load their inputs.
REQ-018 A stall SHALL last exactly one cycle per load-use pair: after the bubble, ctl_mem_read_IDEX_o=0, so stall_o deasserts.
REQ-019 bubble_count_o SHALL increment by 1 on each bubble cycle and saturate at 16'hFFFF (no wrap).
REQ-020 Stall and flush in the same cycle SHALL count as one bubble.
REQ-021 Register-field equality SHALL be full 5-bit compare; register 0 never triggers a stall.

Reset
REQ-022 On reset=1, all _IDEX_o outputs and bubble_count_o SHALL clear to 0 immediately, independent of clk.
REQ-023 During and after reset, stall_o SHALL be 0 (IDEX mem_read cleared), so pc_write_o=if_id_write_o=1.
REQ-024 Reset asserted mid-stall SHALL abort the stall; the first post-reset edge SHALL load inputs normally.

Structure
REQ-025 ALU op encodings and the bubble control word (all zeros) SHALL be shared constants in the pipeline package.
REQ-026 Load-use detection SHALL be a sub-module hazard_detection_unit (combinational); id_ex_stage holds registers and counter.

Verification
REQ-027 Pass-through: rd1=32'h1234_5678, rs=3, rt=4, rd=5, reg_write=1, no hazard -> next cycle IDEX outputs equal inputs, stall_o=0.
REQ-028 Load-use: IDEX holds lw (mem_read=1, rt=8); ID rs=8 -> stall_o=1, pc_write_o=0, if_id_write_o=0; next edge ctl outputs=0, bubble_count_o=1; following cycle stall_o=0.
REQ-029 Load to $0: IDEX mem_read=1, rt=0; ID rs=0 -> stall_o=0, no bubble.
REQ-030 Flush over stall: load-use condition plus flush_i=1 -> stall_o=0, pc_write_o=1, ctl outputs 0 next cycle, bubble_count_o +1 only.
REQ-031 Saturation: preload 65534 bubbles, force 3 more -> bubble_count_o=16'hFFFF, stays there.
REQ-032 Async reset: assert reset between edges during a stall -> all outputs 0 before next edge, stall_o=0.
